// File: rtl/wb_pkg.sv
// Shared types for the write-back unit: source tag and registered write request.
`include "config.svh"

package wb_pkg;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LSU  = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [`REG_AW-1:0] addr;
        logic [`XLEN-1:0]   data;
        wb_src_e            src;
    } wb_req_t;

endpackage

// File: rtl/config.svh
// Global width and count constants shared by the write-back block and its package.
`ifndef CONFIG_SVH
`define CONFIG_SVH
`define XLEN    32
`define REG_AW  5
`define REG_NUM 32
`endif

// File: rtl/wb_scoreboard.sv
// Per-register busy tracking for long-latency results, operand stall lookup and
// a sticky protocol-error flag.
`include "config.svh"

module wb_scoreboard #(
    parameter int REG_AW  = `REG_AW,
    parameter int REG_NUM = `REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic              lsu_hs,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic              pipe_wr_en,
    input  logic [REG_AW-1:0] pipe_wr_addr,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              chk_stall,
    output logic              sb_err
);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic               err_q, err_d;
    logic               same_clr;

    assign same_clr = clr_en & (clr_addr == iss_rd);

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_addr] = 1'b0;
        if (iss_valid)
            busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q
              | (lsu_hs & (lsu_rd != '0) & ~busy_q[lsu_rd])
              | (iss_valid & busy_q[iss_rd] & ~same_clr)
              | (pipe_wr_en & busy_q[pipe_wr_addr]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign chk_stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    assign sb_err    = err_q;

endmodule

// File: rtl/regfile_wb.sv
// Register-file write port owner: fixed-priority merge of pipeline and long-latency
// results into one registered write per cycle, plus the busy scoreboard.
`include "config.svh"

module regfile_wb
    import wb_pkg::*;
#(
    parameter int XLEN    = `XLEN,
    parameter int REG_AW  = `REG_AW,
    parameter int REG_NUM = `REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr_en,
    input  logic [REG_AW-1:0] pipe_wr_addr,
    input  logic [XLEN-1:0]   pipe_wr_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              chk_stall,
    output logic              rd_write,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              sb_err
);

    wb_req_t req_q, req_d;
    logic    wr_q, wr_d;
    logic    lsu_hs;

    assign lsu_ready = ~pipe_wr_en;
    assign lsu_hs    = lsu_valid & lsu_ready;

    // With nothing accepted the address/data hold; only the enable drops.
    always_comb begin
        req_d = req_q;
        wr_d  = 1'b0;
        if (pipe_wr_en) begin
            req_d = '{addr: pipe_wr_addr, data: pipe_wr_data, src: WB_SRC_PIPE};
            wr_d  = |pipe_wr_addr;
        end else if (lsu_hs) begin
            req_d = '{addr: lsu_rd, data: lsu_data, src: WB_SRC_LSU};
            wr_d  = |lsu_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '{addr: '0, data: '0, src: WB_SRC_PIPE};
            wr_q  <= 1'b0;
        end else begin
            req_q <= req_d;
            wr_q  <= wr_d;
        end
    end

    assign rd_write = wr_q;
    assign rd_addr  = req_q.addr;
    assign rd_wdata = req_q.data;

    wb_scoreboard #(
        .REG_AW  (REG_AW),
        .REG_NUM (REG_NUM)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .clr_en       (wr_q & (req_q.src == WB_SRC_LSU)),
        .clr_addr     (req_q.addr),
        .lsu_hs       (lsu_hs),
        .lsu_rd       (lsu_rd),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rd       (chk_rd),
        .chk_stall    (chk_stall),
        .sb_err       (sb_err)
    );

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Write-back unit that owns the register-file write port (`rd_addr`/`rd_wdata`/`rd_write`). It merges single-cycle pipeline results with long-latency (load / mul-div) completions, registers the winning write, and keeps a per-register scoreboard so the issue stage can stall on operands and destinations whose long-latency results are still outstanding. It sits between the execute/memory stages and the register file.

## Interface
- `XLEN`, default `` `XLEN `` (32): data width.
- `REG_AW`, default `` `REG_AW `` (5): register address width.
- `REG_NUM`, default `` `REG_NUM `` (32): number of architectural registers.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `pipe_wr_en` in 1: a single-cycle result is present this cycle; it is always accepted.
- `pipe_wr_addr` in REG_AW: destination of the pipeline result.
- `pipe_wr_data` in XLEN: pipeline result data.
- `lsu_valid` in 1: a long-latency result is offered.
- `lsu_ready` out 1: the long-latency result is accepted this cycle.
- `lsu_rd` in REG_AW: destination of the long-latency result.
- `lsu_data` in XLEN: long-latency result data.
- `iss_valid` in 1: a long-latency op is issued this cycle; reserve `iss_rd`.
- `iss_rd` in REG_AW: register to reserve.
- `chk_rs1`, `chk_rs2`, `chk_rd` in REG_AW: addresses of the decoding instruction.
- `chk_stall` out 1: at least one checked register is busy.
- `rd_write` out 1: register-file write enable (registered).
- `rd_addr` out REG_AW: register-file write address (registered).
- `rd_wdata` out XLEN: register-file write data (registered).
- `sb_err` out 1: sticky scoreboard protocol error.

## Operation
- Arbitration: `pipe_wr_en` has fixed priority. `lsu_ready = ~pipe_wr_en`, combinational and independent of `lsu_valid`.
- Accept: accepted source = pipe if `pipe_wr_en`, else lsu if `lsu_valid & lsu_ready`. Its addr/data are captured into `rd_addr`/`rd_wdata`.
- `rd_write` is set on the next edge only if a source was accepted and its address ≠ 0. Writes to x0 are dropped, but an lsu handshake still completes.
- If nothing is accepted, `rd_write` deasserts; `rd_addr`/`rd_wdata` hold their last values.
- Scoreboard: `busy[REG_NUM]`.
  - Set: `iss_valid & iss_rd≠0` sets `busy[iss_rd]`.
  - Clear: `busy[rd_addr]` clears on the edge where `rd_write` is high and the write came from the lsu path (a registered tag bit).
  - Set and clear of the same register on the same edge: set wins.
  - Busy bits for x0 are never set.
- Stall: `chk_stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]`, combinational. Entry 0 always reads 0. Checking `chk_rd` prevents WAW hazards.
- `sb_err` is set (and held until reset) in any of these cases:
  - lsu handshake to a non-busy, nonzero register;
  - `iss_valid` to an already-busy register with no same-edge clear;
  - `pipe_wr_en` to a busy register.

## Timing
- Reset values (asynchronous assert): `rd_write=0`, `rd_addr=0`, `rd_wdata=0`, all `busy=0`, `sb_err=0`, lsu tag 0. In-flight reservations are discarded.
- Latency: result accepted in cycle N → `rd_write` high in N+1 → register-file contents updated at the end of N+1 → readable in N+2.
- Busy clear lands at the end of N+1, so `chk_stall` for that register drops in N+2. This is exactly when the register file holds the value, so no bypass is needed.
- Reservation at the edge ending cycle I → `chk_stall` is high from I+1.
- Back-to-back: one write per cycle. Continuous `pipe_wr_en` starves lsu indefinitely, which is permitted.

## Structure
- Width and count constants come from `config.svh`.
- A shared package `wb_pkg` holds the source-tag enum (`WB_SRC_PIPE`, `WB_SRC_LSU`) and the write-request struct `{addr, data, src}`.
- Sub-module `wb_scoreboard`: busy vector, set/clear logic, three-port stall lookup and `sb_err`.
- `regfile_wb` contains the arbiter and the output registers.

## Test plan
- Reset mid-stream: `busy[5]` set, `rd_write=1`, then `rst` → all outputs 0 immediately, `chk_stall=0` for `chk_rs1=5`.
- Pipe write x3=0x1234 in cycle N → `rd_write=1`, `rd_addr=3`, `rd_wdata=0x1234` in N+1; `rd_write=0` in N+2.
- Issue x7, then lsu result x7=0xDEADBEEF in cycle N → `chk_stall` is 1 with `chk_rs2=7` through N+1, then 0 in N+2; `sb_err=0`.
- `pipe_wr_en` and `lsu_valid` together (pipe x1, lsu x2) → `lsu_ready=0`; x1 written in N+1; x2 written in N+2 after pipe drops.
- Write to x0 from both paths → `rd_write` stays 0; lsu handshake completes; `iss_valid` with `iss_rd=0` leaves `chk_stall=0`.
- Error cases: lsu completion to non-busy x9 → `sb_err=1`, held. Issue x4 twice → `sb_err=1`. Same-edge clear and reissue of x4 → `busy[4]=1`, `sb_err=0`.
